// File: rtl/mmul_pkg.sv
// Shared types and elaboration checks for the matrix-multiply loop sequencer.
package mmul_pkg;

  localparam int unsigned IDX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // True when the loop bounds and pipeline latency describe a buildable sequencer.
  function automatic bit params_legal(input int unsigned ra, input int unsigned ca,
                                      input int unsigned rb, input int unsigned cb,
                                      input int unsigned lat);
    return (ra != 0) && (ca != 0) && (rb != 0) && (cb != 0) && (ca == rb) && (lat <= 15);
  endfunction

endpackage

// File: rtl/mmul_delay_line.sv
// Fixed-depth shift register aligning {acc_last, i, j} with the MAC pipeline output.
module mmul_delay_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];

    // Advance one stage every cycle; issue stalls do not freeze the datapath.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int unsigned s = 0; s < DEPTH; s++) sr[s] <= '0;
      end else begin
        sr[0] <= d;
        for (int unsigned s = 1; s < DEPTH; s++) sr[s] <= sr[s-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/mmul_sequencer.sv
// Matrix-multiply loop controller: issues (i, j, k) tuples, accumulator strobes,
// a latency-matched result write, and a start/busy/done handshake.
module mmul_sequencer
  import mmul_pkg::*;
#(
  parameter int unsigned RA      = 0,
  parameter int unsigned CA      = 0,
  parameter int unsigned RB      = 0,
  parameter int unsigned CB      = 0,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic [IDX_W-1:0] k,
  output logic             valid,
  output logic             acc_clr,
  output logic             acc_last,
  output logic             res_we,
  output logic [IDX_W-1:0] res_i,
  output logic [IDX_W-1:0] res_j,
  output logic             busy,
  output logic             done
);

  if (!params_legal(RA, CA, RB, CB, MAC_LAT)) begin : g_bad_params
    $error("mmul_sequencer: illegal RA/CA/RB/CB/MAC_LAT combination");
  end

  localparam logic [IDX_W-1:0] I_MAX      = IDX_W'(RA - 1);
  localparam logic [IDX_W-1:0] J_MAX      = IDX_W'(CB - 1);
  localparam logic [IDX_W-1:0] K_MAX      = IDX_W'(RB - 1);
  localparam logic [3:0]       DRAIN_LOAD = 4'(MAC_LAT - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] i_n, j_n, k_n;
  logic [3:0]       cnt, cnt_n;

  // State, index counters and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      i     <= i_n;
      j     <= j_n;
      k     <= k_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, index stepping and issue strobes.
  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    k_n      = k;
    cnt_n    = cnt;
    valid    = 1'b0;
    acc_clr  = 1'b0;
    acc_last = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
        end
      end
      RUN: begin
        valid    = !stall;
        acc_clr  = !stall && (k == '0);
        acc_last = !stall && (k == K_MAX);
        if (!stall) begin
          if (k == K_MAX) begin
            k_n = '0;
            if (j == J_MAX) begin
              j_n = '0;
              if (i == I_MAX) begin
                i_n     = '0;
                cnt_n   = DRAIN_LOAD;
                state_n = (MAC_LAT > 0) ? DRAIN : DONE;
              end else begin
                i_n = i + IDX_W'(1);
              end
            end else begin
              j_n = j + IDX_W'(1);
            end
          end else begin
            k_n = k + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 4'd1;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [2*IDX_W:0] dl_d, dl_q;
  assign dl_d = {acc_last, i, j};

  mmul_delay_line #(
    .DEPTH(MAC_LAT),
    .W    (2*IDX_W + 1)
  ) u_delay (
    .clk(clk),
    .rst(rst),
    .d  (dl_d),
    .q  (dl_q)
  );

  assign res_we = dl_q[2*IDX_W];
  assign res_i  = dl_q[2*IDX_W-1:IDX_W];
  assign res_j  = dl_q[IDX_W-1:0];

endmodule

// File: tb/tb_mmul_sequencer.sv
// Scoreboard bench for mmul_sequencer: two configurations, random stalls,
// ignored starts, back-to-back runs and a mid-run abort.
module tb_mmul_sequencer;

  localparam int unsigned A_RA = 2, A_CA = 3, A_RB = 3, A_CB = 2, A_LAT = 2;
  localparam int unsigned B_RA = 1, B_CA = 1, B_RB = 1, B_CB = 1, B_LAT = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        a_rst, a_start, a_stall, a_valid, a_acc_clr, a_acc_last, a_res_we, a_busy, a_done;
  logic [31:0] a_i, a_j, a_k, a_ri, a_rj;
  logic        b_rst, b_start, b_stall, b_valid, b_acc_clr, b_acc_last, b_res_we, b_busy, b_done;
  logic [31:0] b_i, b_j, b_k, b_ri, b_rj;

  mmul_sequencer #(.RA(A_RA), .CA(A_CA), .RB(A_RB), .CB(A_CB), .MAC_LAT(A_LAT)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .stall(a_stall),
    .i(a_i), .j(a_j), .k(a_k), .valid(a_valid), .acc_clr(a_acc_clr), .acc_last(a_acc_last),
    .res_we(a_res_we), .res_i(a_ri), .res_j(a_rj), .busy(a_busy), .done(a_done)
  );

  mmul_sequencer #(.RA(B_RA), .CA(B_CA), .RB(B_RB), .CB(B_CB), .MAC_LAT(B_LAT)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .stall(b_stall),
    .i(b_i), .j(b_j), .k(b_k), .valid(b_valid), .acc_clr(b_acc_clr), .acc_last(b_acc_last),
    .res_we(b_res_we), .res_i(b_ri), .res_j(b_rj), .busy(b_busy), .done(b_done)
  );

  typedef struct {
    int unsigned i, j, k;
    bit          clr, last;
    int          c;
  } tup_t;

  typedef struct {
    int unsigned i, j;
    int          c;
  } res_t;

  tup_t tq[2][$];
  res_t rq[2][$];
  int   dq[2][$];
  int   bfrom[2] = '{1, 1};
  int   bto[2]   = '{0, 0};
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, d, cyc, got, exp);
    end
  endtask

  task automatic flag(input string nm, input int d, input int exp_c);
    checks++;
    failures++;
    $display("FAIL %s dut%0d cyc=%0d expected_cycle=%0d", nm, d, cyc, exp_c);
  endtask

  task automatic mon(input int d, input logic r, input logic v, input logic clr, input logic last,
                     input logic rwe, input logic bsy, input logic dn,
                     input logic [31:0] ii, input logic [31:0] jj, input logic [31:0] kk,
                     input logic [31:0] ri, input logic [31:0] rj);
    tup_t t;
    res_t rs;
    int   dc;
    if (r) begin
      chk("reset_strobes", d, {122'd0, v, clr, last, rwe, bsy, dn}, '0);
      chk("reset_indices", d, {96'd0, ii | jj | kk | ri | rj}, '0);
      return;
    end
    chk("busy", d, {127'd0, bsy}, {127'd0, (cyc >= bfrom[d]) && (cyc <= bto[d])});
    while (tq[d].size() > 0 && tq[d][0].c < cyc) begin
      flag("missed_tuple", d, tq[d][0].c);
      void'(tq[d].pop_front());
    end
    while (rq[d].size() > 0 && rq[d][0].c < cyc) begin
      flag("missed_res_we", d, rq[d][0].c);
      void'(rq[d].pop_front());
    end
    while (dq[d].size() > 0 && dq[d][0] < cyc) begin
      flag("missed_done", d, dq[d][0]);
      void'(dq[d].pop_front());
    end
    if (v) begin
      if (tq[d].size() == 0) flag("unexpected_valid", d, -1);
      else begin
        t = tq[d].pop_front();
        chk("tuple_ijk", d, {32'd0, ii, jj, kk}, {32'd0, t.i, t.j, t.k});
        chk("tuple_cycle", d, 128'(cyc), 128'(t.c));
        chk("acc_clr", d, {127'd0, clr}, {127'd0, t.clr});
        chk("acc_last", d, {127'd0, last}, {127'd0, t.last});
      end
    end else begin
      chk("strobes_without_valid", d, {126'd0, clr, last}, '0);
    end
    if (rwe) begin
      if (rq[d].size() == 0) flag("unexpected_res_we", d, -1);
      else begin
        rs = rq[d].pop_front();
        chk("res_addr", d, {64'd0, ri, rj}, {64'd0, rs.i, rs.j});
        chk("res_cycle", d, 128'(cyc), 128'(rs.c));
      end
    end
    if (dn) begin
      if (dq[d].size() == 0) flag("unexpected_done", d, -1);
      else begin
        dc = dq[d].pop_front();
        chk("done_cycle", d, 128'(cyc), 128'(dc));
      end
    end
  endtask

  always @(negedge clk)
    mon(0, a_rst, a_valid, a_acc_clr, a_acc_last, a_res_we, a_busy, a_done, a_i, a_j, a_k, a_ri, a_rj);
  always @(negedge clk)
    mon(1, b_rst, b_valid, b_acc_clr, b_acc_last, b_res_we, b_busy, b_done, b_i, b_j, b_k, b_ri, b_rj);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic st, input logic sl);
    if (d == 0) begin a_start = st; a_stall = sl; end
    else        begin b_start = st; b_stall = sl; end
  endtask

  task automatic set_rst(input int d, input logic r);
    if (d == 0) a_rst = r;
    else        b_rst = r;
  endtask

  function automatic logic outs_zero(input int d);
    if (d == 0)
      return !(a_valid | a_acc_clr | a_acc_last | a_res_we | a_busy | a_done) &&
             ((a_i | a_j | a_k | a_ri | a_rj) == 32'd0);
    return !(b_valid | b_acc_clr | b_acc_last | b_res_we | b_busy | b_done) &&
           ((b_i | b_j | b_k | b_ri | b_rj) == 32'd0);
  endfunction

  task automatic dims(input int d, output int unsigned ra, output int unsigned cb,
                      output int unsigned rb, output int unsigned lat);
    if (d == 0) begin ra = A_RA; cb = A_CB; rb = A_RB; lat = A_LAT; end
    else        begin ra = B_RA; cb = B_CB; rb = B_RB; lat = B_LAT; end
  endtask

  // One run: drives start, then per cycle the stall pattern; the reference model
  // walks the row-major loop nest and predicts every issue, write and done cycle.
  // stall_mode: 0 none, 1 cycles 2..4, 2 random. ign: extra starts at cycle 3 and done cycle.
  task automatic run(input int d, input int stall_mode, input bit ign, input int abort_rel);
    int unsigned ra, cb, rb, lat, n_tot, n, ii, jj, kk;
    int          c0, done_c;
    bit          s;
    tup_t        t;
    res_t        rs;
    dims(d, ra, cb, rb, lat);
    n_tot = ra * cb * rb;
    tick();
    c0 = cyc;
    set_in(d, 1'b1, 1'b0);
    bfrom[d] = c0 + 1;
    bto[d]   = 2147483647;
    n        = 0;
    done_c   = 0;
    for (int r = 1; r < 2000; r++) begin
      tick();
      if (abort_rel != 0 && r == abort_rel) begin
        set_in(d, 1'b0, 1'b0);
        set_rst(d, 1'b1);
        tq[d].delete();
        rq[d].delete();
        dq[d].delete();
        bfrom[d] = 1;
        bto[d]   = 0;
        #1;
        chk("abort_outputs_zero", d, {127'd0, outs_zero(d)}, 128'd1);
        tick();
        tick();
        set_rst(d, 1'b0);
        return;
      end
      case (stall_mode)
        1:       s = (r >= 2 && r <= 4);
        2:       s = (r < 300) && ($urandom_range(0, 2) == 0);
        default: s = 1'b0;
      endcase
      set_in(d, ign && (r == 3 || cyc == done_c), s);
      if (!s && n < n_tot) begin
        ii     = n / (cb * rb);
        jj     = (n / rb) % cb;
        kk     = n % rb;
        t.i    = ii;
        t.j    = jj;
        t.k    = kk;
        t.clr  = (kk == 0);
        t.last = (kk == rb - 1);
        t.c    = cyc;
        tq[d].push_back(t);
        if (t.last) begin
          rs.i = ii;
          rs.j = jj;
          rs.c = cyc + int'(lat);
          rq[d].push_back(rs);
        end
        n++;
        if (n == n_tot) begin
          done_c = cyc + int'(lat) + 1;
          dq[d].push_back(done_c);
          bto[d] = done_c;
        end
      end
      if (done_c != 0 && cyc == done_c) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 1'b0; a_stall = 1'b0;
    b_start = 1'b0; b_stall = 1'b0;
    repeat (3) tick();
    a_rst = 1'b0; b_rst = 1'b0;
    // Idle with start low; stall toggling must have no effect.
    repeat (20) begin
      tick();
      set_in(0, 1'b0, 1'($urandom_range(0, 1)));
      set_in(1, 1'b0, 1'($urandom_range(0, 1)));
    end
    run(0, 0, 1'b0, 0);
    run(0, 1, 1'b0, 0);
    run(0, 0, 1'b1, 0);
    run(0, 0, 1'b0, 0);
    run(0, 0, 1'b0, 7);
    run(0, 0, 1'b0, 0);
    repeat (3) run(0, 2, 1'b0, 0);
    run(0, 2, 1'b1, 0);
    run(0, 0, 1'b0, 0);
    tick();
    set_in(0, 1'b0, 1'b0);
    run(1, 0, 1'b0, 0);
    repeat (3) run(1, 2, 1'b0, 0);
    run(1, 0, 1'b1, 0);
    run(1, 0, 1'b0, 0);
    run(1, 0, 1'b0, 2);
    run(1, 0, 1'b0, 0);
    repeat (6) begin
      tick();
      set_in(0, 1'b0, 1'b0);
      set_in(1, 1'b0, 1'b0);
    end
    for (int d = 0; d < 2; d++) begin
      chk("tuples_outstanding", d, 128'(tq[d].size()), '0);
      chk("writes_outstanding", d, 128'(rq[d].size()), '0);
      chk("dones_outstanding", d, 128'(dq[d].size()), '0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
